// File: rtl/cpu_axi_bridge_burst.sv
`timescale 1ns/1ps
// CPU sram-like instruction/data ports bridged onto a single AXI3 master.
// Fetches become INCR line refills; stores drain through an in-order write buffer.
module cpu_axi_bridge_burst #(
    parameter int INST_BURST_LEN = 8,
    parameter int WB_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    output logic        inst_last,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        wb_full,
    output logic        wb_empty,
    output logic        bresp_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    localparam int              LB        = $clog2(INST_BURST_LEN) + 2;
    localparam int              PW        = $clog2(WB_DEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(WB_DEPTH);
    localparam logic [31:0]     LINE_MASK = ~((32'd1 << LB) - 32'd1);
    localparam logic [7:0]      INST_LEN  = 8'(INST_BURST_LEN - 1);

    typedef enum logic [1:0] {I_IDLE, I_AR, I_R} ist_e;
    typedef enum logic [1:0] {D_IDLE, D_HAZ, D_AR, D_R} dst_e;

    function automatic logic [31:0] axi_map(input logic [31:0] a);
        return {3'b000, a[28:0]};
    endfunction

    ist_e        ist_q, ist_d;
    dst_e        dst_q, dst_d;
    logic [31:0] i_addr_q, i_addr_d;
    logic [31:0] d_addr_q, d_addr_d;
    logic [2:0]  d_size_q, d_size_d;
    logic        ar_own_q, ar_lock_q;
    logic        ar_data_sel, ar_hs, i_beat, d_beat, load_ok;
    logic        haz_new, haz_cur;

    logic [31:0]         wb_addr_q [WB_DEPTH];
    logic [2:0]          wb_size_q [WB_DEPTH];
    logic [3:0]          wb_strb_q [WB_DEPTH];
    logic [31:0]         wb_data_q [WB_DEPTH];
    logic [WB_DEPTH-1:0] wb_vld_q, wb_vld_d;
    logic [PW-1:0]       push_ptr_q, aw_ptr_q, w_ptr_q, b_ptr_q;
    logic [CW-1:0]       count_q, count_d, na_q, na_d, nw_q, nw_d, ncur;
    logic                push, aw_hs, w_hs, b_hs, bresp_err_q;
    logic                unused_ok;

    assign unused_ok = ^{rresp, bresp[0]};

    // Stores still awaiting B compared against the incoming and the held load address.
    always_comb begin
        haz_new = 1'b0;
        haz_cur = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (wb_vld_q[i] && (wb_addr_q[i][31:2] == data_addr[31:2])) haz_new = 1'b1;
            if (wb_vld_q[i] && (wb_addr_q[i][31:2] == d_addr_q[31:2]))  haz_cur = 1'b1;
        end
    end

    // Owner is frozen while an AR handshake is outstanding.
    assign ar_data_sel = ar_lock_q ? ar_own_q : (dst_q == D_AR);
    assign arvalid     = ar_data_sel ? (dst_q == D_AR) : (ist_q == I_AR);
    assign ar_hs       = arvalid & arready;
    assign arid        = ar_data_sel ? 4'd1 : 4'd0;
    assign araddr      = ar_data_sel ? axi_map(d_addr_q) : axi_map(i_addr_q);
    assign arlen       = ar_data_sel ? 8'd0 : INST_LEN;
    assign arsize      = ar_data_sel ? d_size_q : 3'd2;
    assign arburst     = 2'b01;

    assign rready       = (ist_q == I_R) | (dst_q == D_R);
    assign i_beat       = rvalid & rready & (rid == 4'd0) & (ist_q == I_R);
    assign d_beat       = rvalid & rready & (rid == 4'd1) & (dst_q == D_R);
    assign inst_data_ok = i_beat;
    assign inst_last    = i_beat & rlast;
    assign inst_rdata   = rdata;
    assign data_data_ok = d_beat;
    assign data_rdata   = rdata;

    always_comb begin
        ist_d        = ist_q;
        i_addr_d     = i_addr_q;
        inst_addr_ok = 1'b0;
        case (ist_q)
            I_IDLE: if (inst_req) begin
                inst_addr_ok = 1'b1;
                i_addr_d     = inst_addr & LINE_MASK;
                ist_d        = I_AR;
            end
            I_AR:    if (ar_hs && !ar_data_sel) ist_d = I_R;
            I_R:     if (i_beat && rlast) ist_d = I_IDLE;
            default: ist_d = I_IDLE;
        endcase
    end

    always_comb begin
        dst_d    = dst_q;
        d_addr_d = d_addr_q;
        d_size_d = d_size_q;
        load_ok  = 1'b0;
        case (dst_q)
            D_IDLE: if (data_req && !data_wr) begin
                load_ok  = 1'b1;
                d_addr_d = data_addr;
                d_size_d = data_size;
                dst_d    = haz_new ? D_HAZ : D_AR;
            end
            D_HAZ:   if (!haz_cur) dst_d = D_AR;
            D_AR:    if (ar_hs && ar_data_sel) dst_d = D_R;
            D_R:     if (d_beat) dst_d = D_IDLE;
            default: dst_d = D_IDLE;
        endcase
    end

    assign wb_full      = (count_q == FULL_CNT);
    assign wb_empty     = (count_q == '0);
    assign push         = data_req & data_wr & ~wb_full;
    assign data_addr_ok = push | load_ok;

    assign awvalid = (na_q != '0);
    assign wvalid  = (nw_q != '0);
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    // Entries past both AW and W (and not yet answered) are those beyond the larger backlog.
    assign ncur    = (na_q > nw_q) ? na_q : nw_q;
    assign bready  = (count_q > ncur);
    assign b_hs    = bvalid & bready & (bid == 4'd2);

    assign awid    = 4'd2;
    assign awaddr  = axi_map(wb_addr_q[aw_ptr_q]);
    assign awlen   = 8'd0;
    assign awsize  = wb_size_q[aw_ptr_q];
    assign awburst = 2'b01;
    assign wid     = 4'd2;
    assign wdata   = wb_data_q[w_ptr_q];
    assign wstrb   = wb_strb_q[w_ptr_q];
    assign wlast   = 1'b1;
    assign bresp_err = bresp_err_q;

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(b_hs);
        na_d     = na_q + CW'(push) - CW'(aw_hs);
        nw_d     = nw_q + CW'(push) - CW'(w_hs);
        wb_vld_d = wb_vld_q;
        if (b_hs) wb_vld_d[b_ptr_q] = 1'b0;
        if (push) wb_vld_d[push_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[push_ptr_q] <= data_addr;
            wb_size_q[push_ptr_q] <= data_size;
            wb_strb_q[push_ptr_q] <= data_wstrb;
            wb_data_q[push_ptr_q] <= data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ist_q       <= I_IDLE;
            dst_q       <= D_IDLE;
            i_addr_q    <= '0;
            d_addr_q    <= '0;
            d_size_q    <= '0;
            ar_own_q    <= 1'b0;
            ar_lock_q   <= 1'b0;
            wb_vld_q    <= '0;
            push_ptr_q  <= '0;
            aw_ptr_q    <= '0;
            w_ptr_q     <= '0;
            b_ptr_q     <= '0;
            count_q     <= '0;
            na_q        <= '0;
            nw_q        <= '0;
            bresp_err_q <= 1'b0;
        end else begin
            ist_q     <= ist_d;
            dst_q     <= dst_d;
            i_addr_q  <= i_addr_d;
            d_addr_q  <= d_addr_d;
            d_size_q  <= d_size_d;
            ar_own_q  <= ar_data_sel;
            ar_lock_q <= arvalid & ~arready;
            wb_vld_q  <= wb_vld_d;
            count_q   <= count_d;
            na_q      <= na_d;
            nw_q      <= nw_d;
            if (push)  push_ptr_q <= push_ptr_q + PW'(1);
            if (aw_hs) aw_ptr_q   <= aw_ptr_q + PW'(1);
            if (w_hs)  w_ptr_q    <= w_ptr_q + PW'(1);
            if (b_hs)  b_ptr_q    <= b_ptr_q + PW'(1);
            if (b_hs && bresp[1]) bresp_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_axi_bridge_burst.sv
`timescale 1ns/1ps
// Directed bench for cpu_axi_bridge_burst: refill, AR arbitration, write buffer, RAW hold, B errors.
module tb_cpu_axi_bridge_burst;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req, inst_addr_ok, inst_data_ok, inst_last;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        wb_full, wb_empty, bresp_err;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, rresp, awburst, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cpu_axi_bridge_burst #(.INST_BURST_LEN(8), .WB_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .inst_last(inst_last),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .wb_full(wb_full), .wb_empty(wb_empty), .bresp_err(bresp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        data_req = 1; data_wr = 1; data_addr = a; data_size = 3'd2;
        data_wstrb = 4'hF; data_wdata = d;
        #1 chk("st_accept", data_addr_ok, 1);
        tick;
        data_req = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] sz);
        data_req = 1; data_wr = 0; data_addr = a; data_size = sz;
        #1 chk("ld_accept", data_addr_ok, 1);
        tick;
        data_req = 0;
    endtask

    task automatic dbeat(input logic [31:0] d);
        rvalid = 1; rid = 4'd1; rdata = d; rlast = 1;
        #1 chk("ld_ok", data_data_ok, 1);
        chk("ld_data", data_rdata, d);
        chk("ld_not_inst", inst_data_ok, 0);
        tick;
        rvalid = 0; rlast = 0;
    endtask

    task automatic inst_drain(output int n);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            rvalid = 1; rid = 4'd0; rdata = 32'h2000 + k; rlast = (k == 7);
            #1 if (inst_data_ok) n++;
            tick;
        end
        rvalid = 0; rlast = 0;
    endtask

    task automatic ar_take;
        arready = 1;
        tick;
        arready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
        $fatal(1);
    end

    initial begin
        int nok, naw, nw, nb, fb, acc, w;
        rst_n = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_addr = 0;
        data_size = 0; data_wstrb = 0; data_wdata = 0; arready = 0; rid = 0; rdata = 0;
        rresp = 0; rlast = 0; rvalid = 0; awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        repeat (2) tick;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_wb_empty", wb_empty, 1);
        chk("rst_wb_full", wb_full, 0);
        chk("rst_berr", bresp_err, 0);
        rst_n = 1;
        tick;

        // line refill
        inst_req = 1; inst_addr = 32'hBFC0_0014;
        #1 chk("if_addr_ok", inst_addr_ok, 1);
        tick;
        inst_req = 0;
        #1;
        chk("if_arvalid", arvalid, 1);
        chk("if_araddr", araddr, 32'h1FC0_0000);
        chk("if_arlen", arlen, 7);
        chk("if_arid", arid, 0);
        chk("if_arsize", arsize, 2);
        chk("if_arburst", arburst, 1);
        ar_take();
        for (int k = 0; k < 8; k++) begin
            rvalid = 1; rid = 0; rdata = 32'h1000 + k; rlast = (k == 7);
            #1 chk("if_beat_ok", inst_data_ok, 1);
            chk("if_beat_data", inst_rdata, 32'h1000 + k);
            chk("if_beat_last", inst_last, (k == 7) ? 1 : 0);
            tick;
        end
        rvalid = 0; rlast = 0;
        #1 chk("if_done_rready", rready, 0);

        // simultaneous fetch and load: data read first, payload held under back-pressure
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        data_req = 1; data_wr = 0; data_addr = 32'h8000_1000; data_size = 3'd2;
        #1 chk("arb_if_ok", inst_addr_ok, 1);
        chk("arb_ld_ok", data_addr_ok, 1);
        tick;
        inst_req = 0; data_req = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("arb_hold_valid", arvalid, 1);
            chk("arb_hold_id", arid, 1);
            chk("arb_hold_addr", araddr, 32'h0000_1000);
            chk("arb_hold_len", arlen, 0);
            tick;
        end
        ar_take();
        for (int i = 0; i < 2; i++) begin
            chk("arb2_valid", arvalid, 1);
            chk("arb2_id", arid, 0);
            chk("arb2_addr", araddr, 32'h1FC0_0100);
            tick;
        end
        ar_take();
        dbeat(32'hDEAD_BEEF);
        inst_drain(nok);
        chk("arb_if_beats", nok, 8);

        // fetch already on AR is not displaced by a later load
        inst_req = 1; inst_addr = 32'hBFC0_0200;
        tick;
        inst_req = 0;
        load(32'h8000_1100, 3'd2);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("lock_id", arid, 0);
            chk("lock_addr", araddr, 32'h1FC0_0200);
            tick;
        end
        ar_take();
        chk("lock_next_id", arid, 1);
        chk("lock_next_addr", araddr, 32'h0000_1100);
        ar_take();
        dbeat(32'h0BAD_F00D);
        inst_drain(nok);
        chk("lock_if_beats", nok, 8);

        // fill the write buffer, then drain it
        chk("wb_start_empty", wb_empty, 1);
        for (int k = 0; k < 5; k++) begin
            data_req = 1; data_wr = 1; data_addr = 32'h8000_3000 + 4 * k;
            data_size = 3'd2; data_wstrb = 4'hF; data_wdata = 32'hA0 + k;
            #1 chk("wb_fill_ok", data_addr_ok, (k < 4) ? 1 : 0);
            if (k < 4) tick;
        end
        chk("wb_full", wb_full, 1);
        chk("wb_full_aw", awvalid, 1);
        awready = 1; wready = 1; bvalid = 1; bid = 4'd2; bresp = 2'b00;
        naw = 0; nw = 0; nb = 0; fb = -1; acc = -1;
        for (int c = 0; c < 40 && nb < 5; c++) begin
            #1;
            if (awvalid && awready) begin
                chk("wb_aw_addr", awaddr, 32'h0000_3000 + 4 * naw);
                naw++;
            end
            if (wvalid && wready) begin
                chk("wb_w_data", wdata, 32'hA0 + nw);
                nw++;
            end
            if (bvalid && bready) begin
                if (fb < 0) fb = c;
                nb++;
            end
            if (data_req && data_addr_ok) acc = c;
            tick;
            if (acc >= 0) data_req = 0;
        end
        awready = 0; wready = 0; bvalid = 0;
        chk("wb_aw_count", naw, 5);
        chk("wb_w_count", nw, 5);
        chk("wb_b_count", nb, 5);
        chk("wb_first_b_cycle", fb, 1);
        chk("wb_fifth_accept_cycle", acc, 2);
        #1 chk("wb_drained", wb_empty, 1);

        // load hitting a buffered store waits for its B
        store(32'h8000_2004, 32'h55);
        load(32'h8000_2006, 3'd1);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("haz_no_ar", arvalid, 0);
            tick;
        end
        awready = 1; wready = 1;
        tick;
        awready = 0; wready = 0;
        #1 chk("haz_bready", bready, 1);
        chk("haz_no_ar_pre_b", arvalid, 0);
        tick;
        bvalid = 1; bid = 4'd2; bresp = 2'b00;
        #1 chk("haz_no_ar_b_cycle", arvalid, 0);
        tick;
        bvalid = 0;
        #1;
        w = 0;
        while (!arvalid && w < 4) begin
            tick;
            w++;
        end
        chk("haz_ar_released", arvalid, 1);
        chk("haz_ar_id", arid, 1);
        chk("haz_ar_addr", araddr, 32'h0000_2006);
        chk("haz_ar_size", arsize, 1);
        ar_take();
        dbeat(32'h1234_0006);

        // non-matching load is not held behind a pending store
        store(32'h8000_2004, 32'h66);
        load(32'h8000_2010, 3'd2);
        #1 chk("nohaz_arvalid", arvalid, 1);
        chk("nohaz_araddr", araddr, 32'h0000_2010);
        ar_take();
        dbeat(32'h0000_2010);
        awready = 1; wready = 1;
        tick;
        awready = 0; wready = 0;
        bvalid = 1; bid = 4'd2; bresp = 2'b00;
        tick;
        bvalid = 0;
        #1 chk("nohaz_wb_empty", wb_empty, 1);

        // W before AW; B error is sticky
        store(32'h8000_4000, 32'h1234_5678);
        wready = 1;
        #1 chk("wfirst_wvalid", wvalid, 1);
        chk("wfirst_wdata", wdata, 32'h1234_5678);
        chk("wfirst_wstrb", wstrb, 4'hF);
        tick;
        wready = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("wfirst_w_done", wvalid, 0);
            chk("wfirst_no_bready", bready, 0);
            chk("wfirst_awvalid", awvalid, 1);
            tick;
        end
        chk("wfirst_awaddr", awaddr, 32'h0000_4000);
        chk("wfirst_awid", awid, 2);
        chk("wfirst_awsize", awsize, 2);
        awready = 1;
        tick;
        awready = 0;
        #1 chk("wfirst_bready", bready, 1);
        chk("wfirst_not_freed", wb_empty, 0);
        bvalid = 1; bid = 4'd2; bresp = 2'b10;
        tick;
        bvalid = 0; bresp = 2'b00;
        #1 chk("berr_set", bresp_err, 1);
        chk("berr_freed", wb_empty, 1);
        store(32'h8000_4008, 32'h1);
        awready = 1; wready = 1;
        tick;
        awready = 0; wready = 0;
        bvalid = 1; bid = 4'd2; bresp = 2'b00;
        tick;
        bvalid = 0;
        #1 chk("berr_sticky", bresp_err, 1);
        chk("berr_okay_freed", wb_empty, 1);

        // reset with traffic pending
        store(32'h8000_5000, 32'h7);
        inst_req = 1; inst_addr = 32'hBFC0_0000;
        tick;
        inst_req = 0;
        rst_n = 0;
        tick;
        chk("rst2_berr", bresp_err, 0);
        chk("rst2_arvalid", arvalid, 0);
        chk("rst2_awvalid", awvalid, 0);
        chk("rst2_wvalid", wvalid, 0);
        chk("rst2_bready", bready, 0);
        chk("rst2_wb_empty", wb_empty, 1);
        rst_n = 1;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
